// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response and memory-pin bundle for mem_access_ctrl.
//   req_valid/req_ready/req_op/req_addr/req_data : operation request handshake
//   rsp_valid/rsp_data/rsp_carry                 : one-cycle completion pulse and result
//   mem_we/mem_addr/mem_wdata/mem_rdata          : pins of the synchronous memory
// Modport slave is the controller side; modport master is the datapath + memory side.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_carry, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single LOAD / STORE / ADD (read-modify-write) / CLEAR operations
// onto a small synchronous memory with one cycle of registered read latency.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mem_access_ctrl_if.slave (request port, response pulse, memory pins)
// One rsp_valid pulse per operation; the controller is back in idle on the edge that raises it.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpStore = 2'b01;
  localparam logic [1:0] OpAdd   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [ADDR_W-1:0] CntLast = '1;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWr,
    StClr
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Holds store data / ADD operand, then the wrapped sum once an ADD has read memory.
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, bus.mem_rdata} + {1'b0, data_q};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          carry_d = 1'b0;
          cnt_d   = '0;
          unique case (bus.req_op)
            OpLoad, OpAdd: state_d = StRdIssue;
            OpStore:       state_d = StWr;
            OpClear:       state_d = StClr;
            default:       state_d = StIdle;
          endcase
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        if (op_q == OpAdd) begin
          data_d  = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
          state_d = StWr;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.mem_rdata;
          rsp_carry_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StWr: begin
        // carry_q is 0 for STORE (cleared on accept), the ADD carry otherwise.
        rsp_valid_d = 1'b1;
        rsp_data_d  = data_q;
        rsp_carry_d = carry_q;
        state_d     = StIdle;
      end
      StClr: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      addr_q      <= '0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;

  // Memory pins depend only on state and latched fields; rst blocks a write on its own edge.
  assign bus.mem_we    = ~rst & ((state_q == StWr) | (state_q == StClr));
  assign bus.mem_addr  = (state_q == StClr) ? cnt_q : addr_q;
  assign bus.mem_wdata = (state_q == StClr) ? '0 : data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench for mem_access_ctrl with a behavioural 4x4 memory
// and an operation-level reference model (expected result, latency and write list per op).
module tb_mem_access_ctrl;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  logic [3:0] mem [4];
  logic [3:0] ref_mem [4];
  int checks = 0;
  int failures = 0;

  mem_access_ctrl_if #(.ADDR_W(2), .DATA_W(4)) bus ();

  mem_access_ctrl #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registered read, write on we.
  always @(posedge clk) begin
    if (mem_init) begin
      mem[0] <= 4'hA;
      mem[1] <= 4'h3;
      mem[2] <= 4'hC;
      mem[3] <= 4'h6;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic void check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endfunction

  // Issue one operation at a negedge with the controller idle; returns at the negedge of the
  // response cycle so the next call is back-to-back.
  task automatic do_op(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data,
                       input bit hold);
    logic [5:0] exp_wr [$];
    logic [5:0] got_wr [$];
    logic [4:0] sum;
    logic [3:0] exp_data;
    logic       exp_carry;
    logic [1:0] a;
    int         exp_lat;
    int         lat;

    exp_carry = 1'b0;
    exp_data  = 4'h0;
    exp_lat   = 0;
    case (op)
      OP_LOAD: begin
        exp_data = ref_mem[addr];
        exp_lat  = 2;
      end
      OP_STORE: begin
        ref_mem[addr] = data;
        exp_data      = data;
        exp_wr.push_back({addr, data});
        exp_lat       = 1;
      end
      OP_ADD: begin
        sum           = 5'(ref_mem[addr]) + 5'(data);
        exp_data      = sum[3:0];
        exp_carry     = sum[4];
        ref_mem[addr] = sum[3:0];
        exp_wr.push_back({addr, sum[3:0]});
        exp_lat       = 3;
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          a          = 2'(i);
          ref_mem[i] = 4'h0;
          exp_wr.push_back({a, 4'h0});
        end
        exp_lat = 4;
      end
    endcase

    check_eq("ready_idle", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    @(posedge clk);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
      check_eq("ready_busy", int'(bus.req_ready), 0);
      if (bus.mem_we) got_wr.push_back({bus.mem_addr, bus.mem_wdata});
      if (hold) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 2'($urandom_range(0, 3));
        bus.req_addr  = 2'($urandom_range(0, 3));
        bus.req_data  = 4'($urandom_range(0, 15));
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_data", int'(bus.rsp_data), int'(exp_data));
    check_eq("rsp_carry", int'(bus.rsp_carry), int'(exp_carry));
    check_eq("ready_at_rsp", int'(bus.req_ready), 1);
    check_eq("write_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check_eq("write_addr_data", int'(got_wr[i]), int'(exp_wr[i]));
  endtask

  // Start an ADD and assert rst during its WR cycle: no write, no response, outputs cleared.
  task automatic rst_during_add(input logic [1:0] addr, input logic [3:0] data);
    bit seen;
    check_eq("ready_idle", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_addr  = addr;
    bus.req_data  = data;
    @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_eq("rst_no_rsp", int'(bus.rsp_valid), 0);
      if (bus.mem_we) seen = 1'b1;
    end
    check_eq("rst_wr_reached", int'(seen), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_we_gated", int'(bus.mem_we), 0);
    @(negedge clk);
    check_eq("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check_eq("rst_rsp_data", int'(bus.rsp_data), 0);
    check_eq("rst_rsp_carry", int'(bus.rsp_carry), 0);
    check_eq("rst_mem_addr", int'(bus.mem_addr), 0);
    check_eq("rst_mem_wdata", int'(bus.mem_wdata), 0);
    check_eq("rst_ready", int'(bus.req_ready), 1);
    check_eq("rst_mem_kept", int'(mem[addr]), int'(ref_mem[addr]));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_quiet", int'(bus.rsp_valid), 0);
    end
  endtask

  initial begin
    bit hold;
    ref_mem[0] = 4'hA;
    ref_mem[1] = 4'h3;
    ref_mem[2] = 4'hC;
    ref_mem[3] = 4'h6;
    rst           = 1'b1;
    mem_init      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = 2'b00;
    bus.req_data  = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", int'(bus.req_ready), 1);
    check_eq("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check_eq("reset_rsp_data", int'(bus.rsp_data), 0);
    check_eq("reset_rsp_carry", int'(bus.rsp_carry), 0);
    check_eq("reset_mem_we", int'(bus.mem_we), 0);
    check_eq("reset_mem_addr", int'(bus.mem_addr), 0);
    check_eq("reset_mem_wdata", int'(bus.mem_wdata), 0);
    rst      = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    // Directed sequence.
    do_op(OP_LOAD, 2'd0, 4'h0, 1'b0);
    do_op(OP_STORE, 2'd2, 4'h5, 1'b0);
    do_op(OP_LOAD, 2'd2, 4'h0, 1'b0);
    do_op(OP_ADD, 2'd0, 4'h7, 1'b1);
    @(negedge clk);
    check_eq("pulse_width", int'(bus.rsp_valid), 0);
    check_eq("rsp_data_held", int'(bus.rsp_data), 1);
    check_eq("rsp_carry_held", int'(bus.rsp_carry), 1);
    do_op(OP_LOAD, 2'd0, 4'h0, 1'b0);
    do_op(OP_STORE, 2'd1, 4'h9, 1'b0);
    do_op(OP_STORE, 2'd3, 4'hE, 1'b0);
    do_op(OP_CLEAR, 2'd2, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) do_op(OP_LOAD, 2'(i), 4'h0, 1'b0);
    do_op(OP_STORE, 2'd3, 4'hB, 1'b0);
    rst_during_add(2'd3, 4'h2);
    do_op(OP_LOAD, 2'd3, 4'h0, 1'b0);

    // Random sequence, occasionally with idle gaps between operations.
    for (int n = 0; n < 60; n++) begin
      hold = 1'($urandom_range(0, 1));
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), hold);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) do_op(OP_LOAD, 2'(i), 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencing controller directly upstream of the 4x4 synchronous memory; the processor datapath issues single memory operations to it over a valid/ready request port.
- Drives the memory's write-enable, address and write-data pins and absorbs the memory's one-cycle registered read latency.
- Returns one response pulse per operation.
- Supported operations: load, store, read-modify-write add, and clear-all.

Parameters:
- ADDR_W, 2, memory address width (depth = 2**ADDR_W).
- DATA_W, 4, memory data width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request this cycle
- req_op  input  2  00 LOAD, 01 STORE, 10 ADD, 11 CLEAR
- req_addr  input  ADDR_W  target address (ignored for CLEAR)
- req_data  input  DATA_W  store data / ADD operand (ignored for LOAD, CLEAR)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  DATA_W  LOAD: read value; STORE/ADD: value written; CLEAR: 0
- rsp_carry  output  1  ADD carry-out; 0 for all other ops
- mem_we  output  1  to memory we
- mem_addr  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory data_in
- mem_rdata  input  DATA_W  from memory data_out (valid the cycle after the address is presented)

Behaviour:
- Reset (rst=1 at a clock edge) forces the following; rst has priority over every other event, including an in-flight operation:
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_carry=0
  - mem_addr=0, mem_wdata=0
  - clear counter=0
  - all latched request fields=0
- mem_we is gated combinationally by !rst, so no memory write occurs on an edge where rst=1.
- req_ready = (state==IDLE); combinational from the state register only. req_ready=0 after reset until rst deasserts? No: it is 1 in the first cycle after reset.
- Accept = req_valid & req_ready at an edge. op/addr/data are latched on accept; req_* are ignored while not IDLE.
- mem_we, mem_addr and mem_wdata are decoded from the state and latched registers only, with no combinational path from req_*. mem_we=0 in every state other than WR and CLR.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, CLR.
- LOAD:
  - IDLE→RD_ISSUE, with mem_addr=addr.
  - →RD_WAIT, where mem_rdata is valid.
  - At the RD_WAIT edge: rsp_data<=mem_rdata, rsp_valid<=1, →IDLE.
  - rsp_valid is high in the cycle after accept edge + 2.
- STORE:
  - IDLE→WR, with mem_we=1, mem_addr=addr, mem_wdata=data.
  - At the WR edge: rsp_valid<=1, rsp_data<=data, →IDLE.
  - Latency is 1 edge after accept.
- ADD:
  - RD_ISSUE→RD_WAIT.
  - At the RD_WAIT edge: sum = {1'b0,mem_rdata} + {1'b0,data} (DATA_W+1 bits); latch wdata<=sum[DATA_W-1:0] and carry<=sum[DATA_W]; →WR.
  - At the WR edge: the memory writes the wrapped sum; rsp_valid<=1, rsp_data<=sum, rsp_carry<=carry; →IDLE.
  - Latency is 3 edges.
- CLEAR:
  - IDLE→CLR with counter=0.
  - Each CLR cycle drives mem_we=1, mem_addr=counter, mem_wdata=0; counter increments on each edge.
  - At the edge where counter==2**ADDR_W-1: counter wraps to 0, rsp_valid<=1, rsp_data<=0, →IDLE.
  - Takes exactly 2**ADDR_W write cycles.
- Response pulse:
  - rsp_valid is exactly one cycle wide, with no backpressure.
  - rsp_data and rsp_carry hold their values until the next response or reset.
  - rsp_carry is cleared to 0 on non-ADD responses.
- Back-to-back requests: the controller returns to IDLE in the same edge that raises rsp_valid, so the next request can be accepted in that cycle (rsp_valid and req_ready are both high).
- The memory's read-before-write behaviour is never exercised: the controller never reads and writes in the same cycle.

Test Plan:
- Reset, then LOAD addr0 (memory preloads location 0 with 4'hA) → rsp_valid high exactly 2 edges after accept, rsp_data=4'hA, rsp_carry=0.
- STORE addr2 data 4'h5, then LOAD addr2 back-to-back → STORE rsp_data=5 after 1 edge; second request accepted in the STORE response cycle; LOAD returns 4'h5.
- ADD addr0 operand 4'h7 with mem[0]=4'hA → single mem_we pulse at addr0 with wdata 4'h1; rsp_data=4'h1, rsp_carry=1 after 3 edges; a following LOAD addr0 returns 4'h1.
- CLEAR after storing nonzero values → mem_we high for exactly 4 consecutive cycles with mem_addr 0,1,2,3 and wdata 0; one rsp_valid pulse; LOADs of all addresses return 0.
- Hold req_valid=1 with varying req_data while an ADD is in flight → req_ready=0 and inputs are not latched; the in-flight result is unaffected; the next request is accepted only when state is IDLE.
- Assert rst during the WR cycle of an ADD → no memory write on that edge (mem[addr] unchanged); rsp_valid never pulses; all outputs return to 0; req_ready=1 next cycle.
